// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat match sequencer.
//   seq_state_t : sequencer FSM states
//   outcome_t   : round result decoded from the hand FSM win lights
//   MAX_DEALS   : most cards a single hand can consume
package baccarat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        REQ,
        STEP,
        CHECK,
        HOLD,
        DONE,
        ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE,
        PLAYER,
        DEALER,
        TIE
    } outcome_t;

    localparam int unsigned MAX_DEALS = 6;
    localparam int unsigned STEP_W    = 3;

    // Both lights lit means a tie.
    function automatic outcome_t decode_outcome(input logic player, input logic dealer);
        outcome_t res;
        case ({player, dealer})
            2'b11:   res = TIE;
            2'b10:   res = PLAYER;
            2'b01:   res = DEALER;
            default: res = NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/baccarat_match_sequencer_sat_counter.sv
// Saturating up-counter used for the per-outcome tallies.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : add one unless already at all-ones
//   q        : count value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/baccarat_match_sequencer.sv
// Match-level sequencer between the card source and the baccarat hand FSM.
// Paces card deals on a req/valid handshake, steps the hand FSM one state per
// card, clears the hand between rounds and tallies the round outcomes.
//   slow_clock, resetb        : clock, async active-high reset
//   start                     : begin a match when not busy
//   card_valid                : card source handshake (accepted while card_req)
//   player_win, dealer_win    : hand FSM result lights
//   card_req/hand_step/hand_clr : mutually exclusive control strobes
//   player/dealer/tie_tally   : saturating outcome counts
//   round_cnt                 : rounds completed this match
//   busy, match_done, err     : status
module baccarat_match_sequencer
    import baccarat_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS   = 8,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned TALLY_W      = 8,
    parameter int unsigned CARD_TIMEOUT = 255
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               start,
    input  logic               card_valid,
    input  logic               player_win,
    input  logic               dealer_win,
    output logic               card_req,
    output logic               hand_step,
    output logic               hand_clr,
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally,
    output logic [7:0]         round_cnt,
    output logic               busy,
    output logic               match_done,
    output logic               err
);

    localparam int unsigned TMR_MAX = (CARD_TIMEOUT > HOLD_CYCLES) ? CARD_TIMEOUT : HOLD_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]  REQ_LAST  = TMR_W'(CARD_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] DEAL_LAST = STEP_W'(MAX_DEALS);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [TMR_W-1:0]  r_timer;
    logic [STEP_W-1:0] r_step_cnt;
    logic [7:0]        r_round_cnt;
    logic              r_card_req;
    logic              r_hand_step;
    logic              r_hand_clr;
    logic              r_busy;
    logic              r_match_done;
    logic              r_err;
    logic              w_match_clr;
    logic              w_score;
    outcome_t          w_outcome;

    // State register.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus match-clear and scoring strobes.
    always_comb begin
        w_state_next = r_state;
        w_match_clr  = 1'b0;
        w_score      = 1'b0;
        w_outcome    = decode_outcome(player_win, dealer_win);
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    w_state_next = CLEAR;
                    w_match_clr  = 1'b1;
                end
            end
            CLEAR: w_state_next = REQ;
            REQ: begin
                // A card arriving on the last timeout cycle is still taken.
                if (card_valid) begin
                    w_state_next = STEP;
                end else if (r_timer == REQ_LAST) begin
                    w_state_next = ERR;
                end
            end
            STEP: w_state_next = CHECK;
            CHECK: begin
                if (w_outcome != NONE) begin
                    w_score      = 1'b1;
                    w_state_next = HOLD;
                end else if (r_step_cnt >= DEAL_LAST) begin
                    w_state_next = ERR;
                end else begin
                    w_state_next = REQ;
                end
            end
            HOLD: begin
                if (r_timer == HOLD_LAST) begin
                    w_state_next = (r_round_cnt == 8'(NUM_ROUNDS)) ? DONE : CLEAR;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shared cycle timer: restarts on every state change, runs in REQ and HOLD.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_timer <= '0;
        end else if (w_state_next != r_state) begin
            r_timer <= '0;
        end else if ((r_state == REQ) || (r_state == HOLD)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Cards dealt in the current hand.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_step_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_step_cnt <= '0;
        end else if (r_state == STEP) begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
        end
    end

    // Completed rounds this match.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_round_cnt <= '0;
        end else if (w_match_clr) begin
            r_round_cnt <= '0;
        end else if (w_score) begin
            r_round_cnt <= r_round_cnt + 8'(1);
        end
    end

    sat_counter #(.W(TALLY_W)) u_player_tally (
        .clk (slow_clock),
        .rst (resetb),
        .clr (w_match_clr),
        .inc (w_score && (w_outcome == PLAYER)),
        .q   (player_tally)
    );

    sat_counter #(.W(TALLY_W)) u_dealer_tally (
        .clk (slow_clock),
        .rst (resetb),
        .clr (w_match_clr),
        .inc (w_score && (w_outcome == DEALER)),
        .q   (dealer_tally)
    );

    sat_counter #(.W(TALLY_W)) u_tie_tally (
        .clk (slow_clock),
        .rst (resetb),
        .clr (w_match_clr),
        .inc (w_score && (w_outcome == TIE)),
        .q   (tie_tally)
    );

    // Moore outputs, registered from the next state so they align with r_state.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            r_card_req   <= 1'b0;
            r_hand_step  <= 1'b0;
            r_hand_clr   <= 1'b0;
            r_busy       <= 1'b0;
            r_match_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_card_req   <= (w_state_next == REQ);
            r_hand_step  <= (w_state_next == STEP);
            r_hand_clr   <= (w_state_next == CLEAR);
            r_busy       <= (w_state_next == CLEAR) || (w_state_next == REQ) ||
                            (w_state_next == STEP)  || (w_state_next == CHECK) ||
                            (w_state_next == HOLD);
            r_match_done <= (w_state_next == DONE);
            r_err        <= (w_state_next == ERR);
        end
    end

    assign card_req   = r_card_req;
    assign hand_step  = r_hand_step;
    assign hand_clr   = r_hand_clr;
    assign round_cnt  = r_round_cnt;
    assign busy       = r_busy;
    assign match_done = r_match_done;
    assign err        = r_err;

endmodule

// File: tb/tb_baccarat_match_sequencer.sv
// Directed bench for baccarat_match_sequencer with a scripted hand FSM stub.
module tb_baccarat_match_sequencer;

    localparam int unsigned TW = 2;

    logic          slow_clock = 1'b0;
    logic          resetb;
    logic          start;
    logic          card_valid;
    logic          player_win;
    logic          dealer_win;
    logic          card_req;
    logic          hand_step;
    logic          hand_clr;
    logic [TW-1:0] player_tally;
    logic [TW-1:0] dealer_tally;
    logic [TW-1:0] tie_tally;
    logic [7:0]    round_cnt;
    logic          busy;
    logic          match_done;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;

    // Per-round script for the hand stub: win bits {player,dealer} and deal count.
    logic [1:0] scr_out   [0:7];
    int         scr_steps [0:7];
    logic [2:0] stub_k;

    baccarat_match_sequencer #(
        .NUM_ROUNDS   (5),
        .HOLD_CYCLES  (3),
        .TALLY_W      (TW),
        .CARD_TIMEOUT (10)
    ) dut (
        .slow_clock   (slow_clock),
        .resetb       (resetb),
        .start        (start),
        .card_valid   (card_valid),
        .player_win   (player_win),
        .dealer_win   (dealer_win),
        .card_req     (card_req),
        .hand_step    (hand_step),
        .hand_clr     (hand_clr),
        .player_tally (player_tally),
        .dealer_tally (dealer_tally),
        .tie_tally    (tie_tally),
        .round_cnt    (round_cnt),
        .busy         (busy),
        .match_done   (match_done),
        .err          (err)
    );

    always #5 slow_clock = ~slow_clock;

    // Hand FSM stand-in: lights the scripted result after the scripted card count.
    always @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            player_win <= 1'b0;
            dealer_win <= 1'b0;
            stub_k     <= '0;
        end else if (hand_clr) begin
            player_win <= 1'b0;
            dealer_win <= 1'b0;
            stub_k     <= '0;
        end else if (hand_step) begin
            stub_k <= stub_k + 3'd1;
            if ((int'(stub_k) + 1) == scr_steps[round_cnt[2:0]]) begin
                player_win <= scr_out[round_cnt[2:0]][1];
                dealer_win <= scr_out[round_cnt[2:0]][0];
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic set_script(input logic [1:0] o0, input int s0, input logic [1:0] o1, input int s1,
                              input logic [1:0] o2, input int s2, input logic [1:0] o3, input int s3,
                              input logic [1:0] o4, input int s4);
        scr_out[0] = o0; scr_steps[0] = s0;
        scr_out[1] = o1; scr_steps[1] = s1;
        scr_out[2] = o2; scr_steps[2] = s2;
        scr_out[3] = o3; scr_steps[3] = s3;
        scr_out[4] = o4; scr_steps[4] = s4;
        for (int i = 5; i < 8; i++) begin
            scr_out[i]   = 2'b00;
            scr_steps[i] = 7;
        end
    endtask

    // Issue start and check the one-cycle start->hand_clr latency.
    task automatic kick(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_clr_lat"}, int'(hand_clr), 1);
    endtask

    // Runs until match_done or err (bounded), collecting handshake statistics.
    task automatic run_match(input int pulse, input int budget, input int poke_rc,
                             output int steps, output int acc, output int mutex,
                             output int last_step, output int end_cyc,
                             output int min_rs, output int max_rs,
                             output int poked_rc, output int poked_busy);
        int rs;
        bit poke_now;
        bit poked;
        steps = 0; acc = 0; mutex = 0; last_step = -1; end_cyc = -1;
        min_rs = 99; max_rs = 0; poked_rc = -1; poked_busy = -1;
        rs = 0; poked = 1'b0;
        for (int c = 0; c < budget; c++) begin
            card_valid = (pulse != 0) ? ((c % 3) == 0) : 1'b1;
            poke_now   = (poke_rc >= 0) && !poked && busy && (int'(round_cnt) == poke_rc);
            start      = poke_now;
            if (card_valid && card_req) acc++;
            tick();
            start = 1'b0;
            if (poke_now) begin
                poked      = 1'b1;
                poked_rc   = int'(round_cnt);
                poked_busy = int'(busy);
            end
            if (hand_step) begin
                steps++;
                rs++;
                last_step = c;
            end
            if ((int'(card_req) + int'(hand_step) + int'(hand_clr)) > 1) mutex++;
            if (hand_clr && (rs > 0)) begin
                if (rs < min_rs) min_rs = rs;
                if (rs > max_rs) max_rs = rs;
                rs = 0;
            end
            if (match_done || err) begin
                end_cyc = c;
                break;
            end
        end
        if (rs > 0) begin
            if (rs < min_rs) min_rs = rs;
            if (rs > max_rs) max_rs = rs;
        end
        card_valid = 1'b0;
    endtask

    initial begin
        int steps, acc, mutex, last_step, end_cyc, min_rs, max_rs, prc, pbusy;
        int rise_c, err_c;

        resetb = 1'b1;
        start = 1'b0;
        card_valid = 1'b0;
        set_script(2'b00, 7, 2'b00, 7, 2'b00, 7, 2'b00, 7, 2'b00, 7);

        // Reset state.
        repeat (3) tick();
        chk("rst_card_req", int'(card_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_round", int'(round_cnt), 0);
        resetb = 1'b0;
        tick();

        // Asynchronous reset while waiting for a card.
        kick("t1");
        tick();
        chk("t1_in_req", int'(card_req), 1);
        #2 resetb = 1'b1;
        #1;
        chk("t1_async_req", int'(card_req), 0);
        chk("t1_async_busy", int'(busy), 0);
        tick();
        resetb = 1'b0;
        repeat (3) tick();
        chk("t1_idle_stays", int'(busy), 0);
        chk("t1_idle_nodone", int'(match_done), 0);

        // Card timeout: err exactly 10 cycles after card_req rises.
        kick("t3");
        rise_c = -1;
        err_c = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (card_req && (rise_c < 0)) rise_c = c;
            if (err && (err_c < 0)) begin
                err_c = c;
                break;
            end
        end
        chk("t3_gap", err_c - rise_c, 10);
        chk("t3_err", int'(err), 1);
        chk("t3_busy", int'(busy), 0);

        // card_valid tied high: P, T, P, P, T with 4/5/6/4/5 cards.
        set_script(2'b10, 4, 2'b11, 5, 2'b10, 6, 2'b10, 4, 2'b11, 5);
        kick("t2");
        run_match(0, 1000, -1, steps, acc, mutex, last_step, end_cyc, min_rs, max_rs, prc, pbusy);
        chk("t2_done", int'(match_done), 1);
        chk("t2_player", int'(player_tally), 3);
        chk("t2_tie", int'(tie_tally), 2);
        chk("t2_dealer", int'(dealer_tally), 0);
        chk("t2_rounds", int'(round_cnt), 5);
        chk("t2_steps", steps, 24);
        chk("t2_mutex", mutex, 0);

        // card_valid every 3rd cycle: P, D, T, D, P with 6/4/5/5/4 cards.
        set_script(2'b10, 6, 2'b01, 4, 2'b11, 5, 2'b01, 5, 2'b10, 4);
        kick("t4");
        chk("t4_tally_clr", int'(player_tally), 0);
        run_match(1, 2000, -1, steps, acc, mutex, last_step, end_cyc, min_rs, max_rs, prc, pbusy);
        chk("t4_done", int'(match_done), 1);
        chk("t4_steps", steps, 24);
        chk("t4_one_per_pulse", acc, 24);
        chk("t4_min_round", min_rs, 4);
        chk("t4_max_round", max_rs, 6);
        chk("t4_mutex", mutex, 0);
        chk("t4_player", int'(player_tally), 2);
        chk("t4_dealer", int'(dealer_tally), 2);
        chk("t4_tie", int'(tie_tally), 1);

        // Hand never resolves: err two cycles after the 6th hand_step.
        set_script(2'b00, 7, 2'b00, 7, 2'b00, 7, 2'b00, 7, 2'b00, 7);
        kick("t5");
        run_match(0, 200, -1, steps, acc, mutex, last_step, end_cyc, min_rs, max_rs, prc, pbusy);
        chk("t5_err", int'(err), 1);
        chk("t5_steps", steps, 6);
        chk("t5_err_lat", end_cyc - last_step, 2);
        chk("t5_rounds", int'(round_cnt), 0);

        // Five dealer wins saturate a 2-bit tally; start while busy is ignored.
        set_script(2'b01, 4, 2'b01, 4, 2'b01, 4, 2'b01, 4, 2'b01, 4);
        kick("t6");
        run_match(0, 1000, 2, steps, acc, mutex, last_step, end_cyc, min_rs, max_rs, prc, pbusy);
        chk("t6_poke_round", prc, 2);
        chk("t6_poke_busy", pbusy, 1);
        chk("t6_done", int'(match_done), 1);
        chk("t6_dealer_sat", int'(dealer_tally), 3);
        chk("t6_rounds", int'(round_cnt), 5);
        repeat (4) tick();
        chk("t6_frozen", int'(dealer_tally), 3);
        kick("t6r");
        chk("t6r_dealer_clr", int'(dealer_tally), 0);
        chk("t6r_round_clr", int'(round_cnt), 0);
        chk("t6r_not_done", int'(match_done), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
